dac_spi_tx: RTL and testbench

- SPI transmitter that sends the audio path's 10-bit offset-binary output sample to the MCP4911 DAC.
- Sits downstream of the echo/processing block: it takes that block's data_out and issues one 16-bit write frame per sample tick, then pulses LDAC.
- It is the sending end of the DAC serial interface. It is the counterpart of the ADC SPI receiver at the front of the path.

---
 rtl/dac_spi_tx.sv | 112 +++++++++++
 tb/tb_dac_spi_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: MCP4911 16-bit SPI write frame plus LDAC strobe per load; DAC_TX_OVERRUN_EN adds a sticky overrun flag
module dac_spi_tx #(
  parameter int CLK_DIV = 25,
  parameter logic [3:0] CMD_BITS = 4'b0011
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_cs_n,
  output logic       dac_ld_n,
  output logic       busy,
  output logic       done,
  output logic       overrun
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, LATCH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bitn, bitn_n;
  logic [15:0] sh, sh_n;
  logic sck_n, sdi_n, cs_n_n, ld_n_n, busy_n, done_n;
  logic last;
  assign last = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bitn <= '0;
      sh <= '0;
      dac_sck <= 1'b0;
      dac_sdi <= 1'b0;
      dac_cs_n <= 1'b1;
      dac_ld_n <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bitn <= bitn_n;
      sh <= sh_n;
      dac_sck <= sck_n;
      dac_sdi <= sdi_n;
      dac_cs_n <= cs_n_n;
      dac_ld_n <= ld_n_n;
      busy <= busy_n;
      done <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + CW'(1);
    bitn_n = bitn;
    sh_n = sh;
    sck_n = dac_sck;
    sdi_n = dac_sdi;
    cs_n_n = dac_cs_n;
    ld_n_n = dac_ld_n;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (load) begin
          state_n = SETUP;
          sh_n = {CMD_BITS, data_in, 2'b00};
          sdi_n = CMD_BITS[3];
          cs_n_n = 1'b0;
          busy_n = 1'b1;
        end
      end
      SETUP: if (last) begin
        state_n = SHIFT;
        bitn_n = '0;
        sck_n = 1'b1;
      end
      SHIFT: if (last) begin
        // falling SCK presents the next bit; the DAC sampled the current one on the rising edge
        if (dac_sck) begin
          sck_n = 1'b0;
          sh_n = {sh[14:0], sh[15]};
          sdi_n = sh[14];
        end else if (bitn == 4'd15) begin
          state_n = LATCH;
          cs_n_n = 1'b1;
          sdi_n = 1'b0;
          ld_n_n = 1'b0;
        end else begin
          sck_n = 1'b1;
          bitn_n = bitn + 4'd1;
        end
      end
      LATCH: if (last) begin
        state_n = IDLE;
        ld_n_n = 1'b1;
        busy_n = 1'b0;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef DAC_TX_OVERRUN_EN
  logic ovr;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) ovr <= 1'b0;
    else ovr <= ovr | (load & busy);
  assign overrun = ovr;
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: randomized frame checks of dac_spi_tx against a word/timing reference model
module tb_dac_spi_tx;
  localparam int D = 4;
  logic sysclk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [9:0] data_in = '0;
  logic dac_sck, dac_sdi, dac_cs_n, dac_ld_n, busy, done, overrun;
  int cyc = 0, nrise, cs_cnt, ld_cnt, busy_cnt, done_cnt, sck_bad;
  int busy_first, busy_last, done_cyc, cs_last, ld_first;
  int n_chk = 0, n_fail = 0;
  logic [15:0] bits;
  logic prev_sck = 1'b0;
  logic exp_ovr;

  always #5 sysclk = ~sysclk;

  dac_spi_tx #(.CLK_DIV(D)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .dac_sck(dac_sck), .dac_sdi(dac_sdi), .dac_cs_n(dac_cs_n), .dac_ld_n(dac_ld_n),
    .busy(busy), .done(done), .overrun(overrun)
  );

  function automatic logic [15:0] ref_word(input logic [9:0] d);
    return {4'b0011, d, 2'b00};
  endfunction

  always @(negedge sysclk) begin
    cyc++;
    if (rst_n) begin
      if (dac_sck && !prev_sck) begin bits = {bits[14:0], dac_sdi}; nrise++; end
      if (!dac_cs_n) begin cs_cnt++; cs_last = cyc; end
      if (!dac_ld_n) begin ld_cnt++; if (ld_first < 0) ld_first = cyc; end
      if (busy) begin busy_cnt++; if (busy_first < 0) busy_first = cyc; busy_last = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (dac_sck && dac_cs_n) sck_bad++;
    end
    prev_sck = dac_sck;
  end

  task automatic clear();
    nrise = 0; cs_cnt = 0; ld_cnt = 0; busy_cnt = 0; done_cnt = 0; sck_bad = 0;
    busy_first = -1; busy_last = -1; done_cyc = -1; cs_last = -1; ld_first = -1; bits = '0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 * D && done_cnt == 0; i++) begin @(negedge sysclk); #1; end
  endtask

  task automatic start(input logic [9:0] d, output int c);
    @(negedge sysclk); #1;
    clear();
    data_in = d; load = 1'b1; c = cyc;
    @(negedge sysclk); #1;
    load = 1'b0; data_in = 10'($urandom);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    n_chk += 7;
    if (dac_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck got %b want 0", dac_sck); end
    if (dac_sdi !== 1'b0) begin n_fail++; $display("FAIL reset_sdi got %b want 0", dac_sdi); end
    if (dac_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", dac_cs_n); end
    if (dac_ld_n !== 1'b1) begin n_fail++; $display("FAIL reset_ld_n got %b want 1", dac_ld_n); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    #1 rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic test_basic();
    int c;
    start(10'h2AA, c);
    wait_done();
    repeat (3) @(negedge sysclk);
    n_chk += 10;
    if (bits !== 16'h3AA8) begin n_fail++; $display("FAIL basic_word got %h want 3aa8", bits); end
    if (nrise != 16) begin n_fail++; $display("FAIL basic_rises got %0d want 16", nrise); end
    if (cs_cnt != 33 * D) begin n_fail++; $display("FAIL basic_cs_low got %0d want %0d", cs_cnt, 33 * D); end
    if (busy_cnt != 34 * D) begin n_fail++; $display("FAIL basic_busy got %0d want %0d", busy_cnt, 34 * D); end
    if (ld_cnt != D) begin n_fail++; $display("FAIL basic_ld_low got %0d want %0d", ld_cnt, D); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    if (ld_first != cs_last + 1) begin n_fail++; $display("FAIL basic_ld_start got %0d want %0d", ld_first, cs_last + 1); end
    if (done_cyc != busy_last + 1) begin n_fail++; $display("FAIL basic_done_pos got %0d want %0d", done_cyc, busy_last + 1); end
    if (busy_first != c + 1) begin n_fail++; $display("FAIL basic_busy_start got %0d want %0d", busy_first, c + 1); end
    if (sck_bad != 0) begin n_fail++; $display("FAIL basic_sck_idle got %0d want 0", sck_bad); end
  endtask

  task automatic test_extremes();
    logic [9:0] v [2] = '{10'h000, 10'h3FF};
    int c;
    for (int k = 0; k < 2; k++) begin
      start(v[k], c);
      wait_done();
      repeat (2) @(negedge sysclk);
      n_chk += 3;
      if (bits !== ref_word(v[k])) begin n_fail++; $display("FAIL extreme_word got %h want %h", bits, ref_word(v[k])); end
      if (nrise != 16) begin n_fail++; $display("FAIL extreme_rises got %0d want 16", nrise); end
      if (sck_bad != 0) begin n_fail++; $display("FAIL extreme_sck_idle got %0d want 0", sck_bad); end
    end
  endtask

  task automatic test_random();
    logic [9:0] d;
    int c;
    for (int k = 0; k < 5; k++) begin
      d = 10'($urandom);
      start(d, c);
      wait_done();
      repeat (2) @(negedge sysclk);
      n_chk += 4;
      if (bits !== ref_word(d)) begin n_fail++; $display("FAIL random_word got %h want %h", bits, ref_word(d)); end
      if (cs_cnt != 33 * D) begin n_fail++; $display("FAIL random_cs_low got %0d want %0d", cs_cnt, 33 * D); end
      if (busy_cnt != 34 * D) begin n_fail++; $display("FAIL random_busy got %0d want %0d", busy_cnt, 34 * D); end
      if (done_cnt != 1) begin n_fail++; $display("FAIL random_done got %0d want 1", done_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] d;
    int c;
    start(10'h1C3, c);
    repeat (60) @(negedge sysclk);
    #1;
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_inframe got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_chk += 5;
    if (dac_sck !== 1'b0) begin n_fail++; $display("FAIL midrst_sck got %b want 0", dac_sck); end
    if (dac_cs_n !== 1'b1) begin n_fail++; $display("FAIL midrst_cs_n got %b want 1", dac_cs_n); end
    if (dac_ld_n !== 1'b1) begin n_fail++; $display("FAIL midrst_ld_n got %b want 1", dac_ld_n); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (dac_sdi !== 1'b0) begin n_fail++; $display("FAIL midrst_sdi got %b want 0", dac_sdi); end
    repeat (5) @(negedge sysclk);
    #1 rst_n = 1'b1;
    repeat (200) @(negedge sysclk);
    n_chk += 2;
    if (ld_cnt != 0) begin n_fail++; $display("FAIL midrst_ld_pulse got %0d want 0", ld_cnt); end
    if (done_cnt != 0) begin n_fail++; $display("FAIL midrst_done_pulse got %0d want 0", done_cnt); end
    d = 10'($urandom);
    start(d, c);
    wait_done();
    repeat (2) @(negedge sysclk);
    n_chk += 2;
    if (bits !== ref_word(d)) begin n_fail++; $display("FAIL midrst_next_word got %h want %h", bits, ref_word(d)); end
    if (cs_cnt != 33 * D) begin n_fail++; $display("FAIL midrst_next_cs got %0d want %0d", cs_cnt, 33 * D); end
  endtask

  task automatic test_collision();
    logic [9:0] d;
    int c;
    d = 10'($urandom);
    if (d == 10'h155) d = 10'h0F0;
    start(d, c);
    repeat (49) @(negedge sysclk);
    #1 data_in = 10'h155; load = 1'b1;
    @(negedge sysclk); #1 load = 1'b0;
    wait_done();
    repeat (100) @(negedge sysclk);
`ifdef DAC_TX_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    n_chk += 5;
    if (bits !== ref_word(d)) begin n_fail++; $display("FAIL collide_word got %h want %h", bits, ref_word(d)); end
    if (nrise != 16) begin n_fail++; $display("FAIL collide_rises got %0d want 16", nrise); end
    if (busy_cnt != 34 * D) begin n_fail++; $display("FAIL collide_busy got %0d want %0d", busy_cnt, 34 * D); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL collide_done got %0d want 1", done_cnt); end
    if (overrun !== exp_ovr) begin n_fail++; $display("FAIL collide_overrun got %b want %b", overrun, exp_ovr); end
  endtask

  task automatic test_back_to_back();
    int c;
    start(10'($urandom), c);
    wait_done();
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got %b want 1", done); end
    clear();
    data_in = 10'h200; load = 1'b1; c = cyc;
    @(negedge sysclk); #1 load = 1'b0; data_in = 10'($urandom);
    wait_done();
    repeat (3) @(negedge sysclk);
    n_chk += 6;
    if (busy_first != c + 1) begin n_fail++; $display("FAIL b2b_busy_start got %0d want %0d", busy_first, c + 1); end
    if (bits !== 16'h3800) begin n_fail++; $display("FAIL b2b_word got %h want 3800", bits); end
    if (busy_cnt != 34 * D) begin n_fail++; $display("FAIL b2b_busy got %0d want %0d", busy_cnt, 34 * D); end
    if (cs_cnt != 33 * D) begin n_fail++; $display("FAIL b2b_cs_low got %0d want %0d", cs_cnt, 33 * D); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_done got %0d want 1", done_cnt); end
    if (done_cyc != busy_last + 1) begin n_fail++; $display("FAIL b2b_done_pos got %0d want %0d", done_cyc, busy_last + 1); end
  endtask

  initial begin
    clear();
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
